udm_shift_accel: RTL and testbench
==================================

// Module: udm_shift_accel
// PURPOSE
//  Multi-cycle shift co-processor, memory-mapped as a slave on the UDM debug bus. Sits directly
//  downstream of the udm bridge on the board top, in parallel with the CSR/testmem decode.
//  The host writes an operand and a command over UART/UDM. The block shifts iteratively and
//  latches the result. The host polls STATUS and reads RESULT. Replaces the combinational shift path.
// PARAMETERS
//  BASE_ADDR  32'h00000100  base of the 16-byte register window; must be 16-byte aligned
//  STEP       1             max bit positions shifted per cycle; legal values 1, 2, 4, 8
// PORTS
//  clk_i         in   1   system clock
//  rst_i         in   1   asynchronous reset, active-high
//  bus_req_i     in   1   UDM bus request
//  bus_we_i      in   1   1 = write, 0 = read
//  bus_addr_bi   in   32  byte address
//  bus_be_bi     in   4   byte enables (writes only)
//  bus_wdata_bi  in   32  write data
//  bus_ack_o     out  1   request accepted
//  bus_resp_o    out  1   read data valid
//  bus_rdata_bo  out  32  read data
//  busy_o        out  1   shift in progress
//  done_o        out  1   sticky completion flag (board LED / irq)
// BEHAVIOUR
//  - Hit: bus_addr_bi[31:4]==BASE_ADDR[31:4]. Register select is addr[3:2].
//    0 DATA (RW), 1 CMD (W; reads back last CMD), 2 STATUS (R/W1C), 3 RESULT (RO).
//  - CMD layout: [0] dir (1=right, 0=left), [1] arith (right only; sign-fill), [6:2] amount 0..31.
//  - STATUS layout: [0] busy, [1] done, [2] err. Writing 1 to [1] or [2] clears that bit.
//    Writes to [0] are ignored.
//  - bus_ack_o = bus_req_i on a hit; 0 otherwise, so misses stay free for other slaves.
//  - Reads: bus_resp_o is a 1-cycle pulse in the cycle after acceptance, with bus_rdata_bo
//    registered. bus_rdata_bo = 0 whenever bus_resp_o = 0. Writes produce no resp.
//  - DATA write honours bus_be_bi per byte. A CMD write uses the full word (be ignored).
//  - FSM IDLE/RUN:
//    - IDLE + CMD write: work<=DATA, cnt<=amount, done<=0. Go to RUN, or, if amount==0,
//      RESULT<=DATA and done<=1 the next cycle, staying in IDLE.
//    - RUN, each cycle: s=min(STEP,cnt); work shifted by s; cnt-=s.
//    - RUN with cnt reaching 0: RESULT<=shifted work, done<=1, go to IDLE.
//    - Latency from CMD accept to done=1 is ceil(amount/STEP) cycles, minimum 1.
//  - Left shifts and logical right shifts zero-fill. Arithmetic right fills with work[31].
//    Results are always 32 bits; bits shifted out are discarded.
//  - During RUN, writes to DATA or CMD are acked but dropped, and set err=1.
//  - RESULT holds the last completed value while busy. DATA reads return the DATA register,
//    not the work register.
//  - A W1C clear and a set of the same bit in one cycle: set wins.
//  - busy_o = (state==RUN); done_o = STATUS[1].
//  - Reset, including mid-RUN: state=IDLE, DATA=CMD=RESULT=work=cnt=0, done=err=0,
//    bus_ack_o=bus_resp_o=0, bus_rdata_bo=0. The aborted shift is lost.
// TESTING
//  - STEP=1: DATA=0x0000_00F0, CMD={amount=4,dir=0} -> busy for 4 cycles,
//    RESULT=0x0000_0F00, done_o=1.
//  - STEP=1: DATA=0x8000_0000, CMD={amount=31,arith=1,dir=1} -> RESULT=0xFFFF_FFFF after
//    31 cycles. Logical right shift of the same operand -> 0x0000_0001.
//  - STEP=4: amount=9 -> done after 3 cycles. amount=0 -> done after 1 cycle, RESULT=DATA.
//  - Write DATA during RUN -> err=1, RESULT unaffected. Write STATUS 0x4 -> err=0.
//  - DATA write with be=4'b0010, wdata 0xAABBCCDD onto DATA=0 -> DATA=0x0000_CC00.
//    Read of BASE_ADDR+0x20 -> ack=0.
//  - Assert rst_i mid-RUN -> busy_o=0, done_o=0, RESULT=0 immediately. A new CMD after
//    release completes normally.

Source files
------------

// File: rtl/udm_shift_accel_if.sv
// UDM debug-bus connection between the bridge (master) and a memory-mapped slave.
interface udm_shift_accel_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, resp, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, resp, rdata
  );
endinterface

// File: rtl/udm_shift_accel.sv
// Iterative shift co-processor on the UDM bus: DATA/CMD/STATUS/RESULT window,
// shifting up to STEP bit positions per cycle until the commanded amount is consumed.
module udm_shift_accel #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned STEP      = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  udm_shift_accel_if.slave     bus,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] R_DATA   = 2'd0;
  localparam logic [1:0] R_CMD    = 2'd1;
  localparam logic [1:0] R_STATUS = 2'd2;
  localparam logic [1:0] R_RESULT = 2'd3;

  localparam logic [4:0] STEP_V = 5'(STEP);

  logic [0:0]  state_q,  state_d;
  logic [31:0] data_q,   data_d;
  logic [31:0] cmd_q,    cmd_d;
  logic [31:0] result_q, result_d;
  logic [31:0] work_q,   work_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic        done_q,   done_d;
  logic        err_q,    err_d;
  logic        zpend_q,  zpend_d;
  logic        resp_q,   resp_d;
  logic [31:0] rdata_q,  rdata_d;

  logic        hit;
  logic        acc;
  logic        wr_data;
  logic        wr_cmd;
  logic        wr_stat;
  logic        rd;
  logic [1:0]  sel;
  logic        run;
  logic [4:0]  step_s;
  logic [31:0] shifted;
  logic        unused_addr_lsb;

  function automatic logic [31:0] shift_by(
    input logic [31:0] w,
    input logic [4:0]  s,
    input logic        dir_right,
    input logic        arith
  );
    logic signed [31:0] sw;
    sw = signed'(w);
    if (!dir_right)
      return w << s;
    else if (arith)
      return unsigned'(sw >>> s);
    else
      return w >> s;
  endfunction

  // Misses leave ack low so other slaves on the bus can answer.
  assign hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign acc     = bus.req & hit & ~rst_i;
  assign sel     = bus.addr[3:2];
  assign wr_data = acc & bus.we & (sel == R_DATA);
  assign wr_cmd  = acc & bus.we & (sel == R_CMD);
  assign wr_stat = acc & bus.we & (sel == R_STATUS);
  assign rd      = acc & ~bus.we;
  assign run     = (state_q == S_RUN);

  assign unused_addr_lsb = ^bus.addr[1:0];

  assign step_s  = (cnt_q < STEP_V) ? cnt_q : STEP_V;
  assign shifted = shift_by(work_q, step_s, cmd_q[0], cmd_q[1]);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cmd_d    = cmd_q;
    result_d = result_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    err_d    = err_q;
    zpend_d  = 1'b0;
    resp_d   = 1'b0;
    rdata_d  = '0;

    // W1C is applied first so any set later in this block takes priority.
    if (wr_stat) begin
      if (bus.wdata[1]) done_d = 1'b0;
      if (bus.wdata[2]) err_d  = 1'b0;
    end

    if (zpend_q) begin
      result_d = work_q;
      done_d   = 1'b1;
    end

    if (wr_data) begin
      if (run) begin
        err_d = 1'b1;
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.be[b]) data_d[8*b +: 8] = bus.wdata[8*b +: 8];
      end
    end

    if (wr_cmd) begin
      if (run) begin
        err_d = 1'b1;
      end else begin
        cmd_d  = bus.wdata;
        work_d = data_q;
        cnt_d  = bus.wdata[6:2];
        done_d = 1'b0;
        if (bus.wdata[6:2] == 5'd0)
          zpend_d = 1'b1;
        else
          state_d = S_RUN;
      end
    end

    if (run) begin
      work_d = shifted;
      cnt_d  = cnt_q - step_s;
      if (cnt_q == step_s) begin
        result_d = shifted;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
    end

    // Read data is captured at acceptance and presented for exactly one cycle.
    if (rd) begin
      resp_d = 1'b1;
      unique case (sel)
        R_DATA:   rdata_d = data_q;
        R_CMD:    rdata_d = cmd_q;
        R_STATUS: rdata_d = {29'd0, err_q, done_q, run};
        R_RESULT: rdata_d = result_q;
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      cmd_q    <= '0;
      result_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      zpend_q  <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cmd_q    <= cmd_d;
      result_q <= result_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      zpend_q  <= zpend_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.ack   = acc;
  assign bus.resp  = resp_q;
  assign bus.rdata = rdata_q;
  assign busy_o    = run;
  assign done_o    = done_q;

endmodule

// File: tb/tb_udm_shift_accel.sv
// Bench for udm_shift_accel: one instance with STEP=1 and one with STEP=4, driven over the UDM bus.
module tb_udm_shift_accel;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, ack_s, resp_s, busy_s, done_s;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];
  logic [31:0] rdata_s [2];
  logic [31:0] last_res [2];

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  udm_shift_accel_if bus0 ();
  udm_shift_accel_if bus1 ();

  assign bus0.req   = req[0];
  assign bus0.we    = we[0];
  assign bus0.addr  = addr[0];
  assign bus0.be    = be[0];
  assign bus0.wdata = wdata[0];
  assign ack_s[0]   = bus0.ack;
  assign resp_s[0]  = bus0.resp;
  assign rdata_s[0] = bus0.rdata;

  assign bus1.req   = req[1];
  assign bus1.we    = we[1];
  assign bus1.addr  = addr[1];
  assign bus1.be    = be[1];
  assign bus1.wdata = wdata[1];
  assign ack_s[1]   = bus1.ack;
  assign resp_s[1]  = bus1.resp;
  assign rdata_s[1] = bus1.rdata;

  udm_shift_accel #(.BASE_ADDR(BASE), .STEP(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .busy_o(busy_s[0]), .done_o(done_s[0])
  );

  udm_shift_accel #(.BASE_ADDR(BASE), .STEP(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1), .busy_o(busy_s[1]), .done_o(done_s[1])
  );

  // Whole-word reference shift; the amount is applied in one go.
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [31:0] c);
    int amt;
    amt = int'(c[6:2]);
    if (!c[0]) return v << amt;
    if (c[1])  return unsigned'($signed(v) >>> amt);
    return v >> amt;
  endfunction

  function automatic int ref_lat(input int d, input logic [31:0] c);
    int amt, st;
    amt = int'(c[6:2]);
    st  = (d == 1) ? 4 : 1;
    return (amt == 0) ? 1 : (amt + st - 1) / st;
  endfunction

  task automatic bus_wr(input int d, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] v, output logic ackv);
    @(negedge clk);
    req[d] = 1'b1; we[d] = 1'b1; addr[d] = a; be[d] = b; wdata[d] = v;
    #1 ackv = ack_s[d];
    @(posedge clk); #1;
    req[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic bus_rd(input int d, input logic [31:0] a, output logic ackv,
                        output logic respv, output logic [31:0] rv);
    @(negedge clk);
    req[d] = 1'b1; we[d] = 1'b0; addr[d] = a; be[d] = 4'h0;
    #1 ackv = ack_s[d];
    @(posedge clk); #1;
    respv = resp_s[d];
    rv    = rdata_s[d];
    req[d] = 1'b0;
  endtask

  // Loads DATA, issues CMD, counts cycles to done and busy cycles, then fetches RESULT.
  task automatic do_shift(input int d, input logic [31:0] v, input logic [31:0] c,
                          output int lat, output int bcnt, output logic [31:0] res);
    logic a, r;
    bus_wr(d, BASE, 4'hF, v, a);
    bus_wr(d, BASE + 32'h4, 4'hF, c, a);
    lat = 0; bcnt = 0;
    while (!done_s[d] && lat < 200) begin
      if (busy_s[d]) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    bus_rd(d, BASE + 32'hC, a, r, res);
  endtask

  task automatic test_reset();
    logic a, r;
    logic [31:0] v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vec++;
      if ({busy_s[d], done_s[d], ack_s[d], resp_s[d], rdata_s[d]} !== 36'h0) begin
        miss++;
        $display("FAIL reset_outputs dut%0d: got %h expected 0", d,
                 {busy_s[d], done_s[d], ack_s[d], resp_s[d], rdata_s[d]});
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_rd(0, BASE + 32'(k * 4), a, r, v);
      vec++;
      if ({a, r, v} !== {2'b11, 32'h0}) begin
        miss++;
        $display("FAIL reset_reg%0d: got ack=%b resp=%b data=%h expected 1 1 00000000", k, a, r, v);
      end
    end
  endtask

  task automatic test_directed();
    int lat, bc;
    logic [31:0] res, v;
    logic [31:0] cmds [3] = '{32'h0000_0010, 32'h0000_007F, 32'h0000_007D};
    logic [31:0] vals [3] = '{32'h0000_00F0, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] exps [3] = '{32'h0000_0F00, 32'hFFFF_FFFF, 32'h0000_0001};
    int          lats [3] = '{4, 31, 31};
    for (int k = 0; k < 3; k++) begin
      do_shift(0, vals[k], cmds[k], lat, bc, res);
      last_res[0] = exps[k];
      vec++;
      if (res !== exps[k] || lat != lats[k] || bc != lats[k] || done_s[0] !== 1'b1) begin
        miss++;
        $display("FAIL directed%0d: got res=%h lat=%0d busy=%0d done=%b expected %h %0d %0d 1",
                 k, res, lat, bc, done_s[0], exps[k], lats[k], lats[k]);
      end
    end
    do_shift(1, 32'h0000_0003, 32'h0000_0024, lat, bc, res);
    vec++;
    if (res !== 32'h0000_0600 || lat != 3 || bc != 3) begin
      miss++;
      $display("FAIL step4_amt9: got res=%h lat=%0d busy=%0d expected 00000600 3 3", res, lat, bc);
    end
    v = 32'hDEAD_BEEF;
    do_shift(1, v, 32'h0000_0003, lat, bc, res);
    last_res[1] = v;
    vec++;
    if (res !== v || lat != 1 || bc != 0) begin
      miss++;
      $display("FAIL step4_amt0: got res=%h lat=%0d busy=%0d expected %h 1 0", res, lat, bc, v);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE;
    @(posedge clk); #1;
    vec++;
    if ({resp_s[0], rdata_s[0]} !== {1'b1, 32'h8000_0000}) begin
      miss++;
      $display("FAIL b2b_read_data: got %b %h expected 1 80000000", resp_s[0], rdata_s[0]);
    end
    addr[0] = BASE + 32'h8;
    @(posedge clk); #1;
    vec++;
    if ({resp_s[0], rdata_s[0]} !== {1'b1, 32'h0000_0002}) begin
      miss++;
      $display("FAIL b2b_read_status: got %b %h expected 1 00000002", resp_s[0], rdata_s[0]);
    end
    req[0] = 1'b0;
    @(posedge clk); #1;
    vec++;
    if ({resp_s[0], rdata_s[0]} !== 33'h0) begin
      miss++;
      $display("FAIL b2b_resp_idle: got %b %h expected 0 00000000", resp_s[0], rdata_s[0]);
    end
  endtask

  task automatic test_random();
    int lat, bc, el, d;
    logic a, r;
    logic [31:0] v, c, res, rb, e;
    for (int i = 0; i < 24; i++) begin
      d = i % 2;
      v = $urandom;
      c = $urandom;
      e = ref_shift(v, c);
      el = ref_lat(d, c);
      do_shift(d, v, c, lat, bc, res);
      last_res[d] = e;
      vec++;
      if (res !== e || lat != el || bc != ((c[6:2] == 5'd0) ? 0 : el)) begin
        miss++;
        $display("FAIL rand%0d dut%0d data=%h cmd=%h: got res=%h lat=%0d busy=%0d expected %h %0d",
                 i, d, v, c, res, lat, bc, e, el);
      end
      bus_rd(d, BASE + 32'h4, a, r, rb);
      vec++;
      if (rb !== c) begin
        miss++;
        $display("FAIL rand%0d_cmd_readback: got %h expected %h", i, rb, c);
      end
      bus_rd(d, BASE + 32'h8, a, r, rb);
      vec++;
      if (rb !== 32'h2) begin
        miss++;
        $display("FAIL rand%0d_status: got %h expected 00000002", i, rb);
      end
    end
  endtask

  task automatic test_err();
    logic a, r;
    logic [31:0] v, c, rb;
    int n;
    v = $urandom;
    c = 32'h0000_0052;
    bus_wr(0, BASE, 4'hF, v, a);
    bus_wr(0, BASE + 32'h4, 4'hF, c, a);
    bus_rd(0, BASE + 32'hC, a, r, rb);
    vec++;
    if (rb !== last_res[0] || busy_s[0] !== 1'b1) begin
      miss++;
      $display("FAIL result_hold_busy: got %h busy=%b expected %h 1", rb, busy_s[0], last_res[0]);
    end
    bus_wr(0, BASE, 4'hF, 32'h1234_5678, a);
    vec++;
    if (a !== 1'b1) begin
      miss++;
      $display("FAIL run_write_ack: got %b expected 1", a);
    end
    bus_wr(0, BASE + 32'h4, 4'hF, 32'h0000_0004, a);
    n = 0;
    while (!done_s[0] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus_rd(0, BASE + 32'hC, a, r, rb);
    vec++;
    if (rb !== ref_shift(v, c)) begin
      miss++;
      $display("FAIL err_result: got %h expected %h", rb, ref_shift(v, c));
    end
    bus_rd(0, BASE, a, r, rb);
    vec++;
    if (rb !== v) begin
      miss++;
      $display("FAIL err_data_kept: got %h expected %h", rb, v);
    end
    bus_rd(0, BASE + 32'h4, a, r, rb);
    vec++;
    if (rb !== c) begin
      miss++;
      $display("FAIL err_cmd_kept: got %h expected %h", rb, c);
    end
    bus_rd(0, BASE + 32'h8, a, r, rb);
    vec++;
    if (rb !== 32'h6) begin
      miss++;
      $display("FAIL err_status: got %h expected 00000006", rb);
    end
    bus_wr(0, BASE + 32'h8, 4'hF, 32'h4, a);
    bus_wr(0, BASE + 32'h8, 4'hF, 32'h1, a);
    bus_rd(0, BASE + 32'h8, a, r, rb);
    vec++;
    if (rb !== 32'h2) begin
      miss++;
      $display("FAIL err_clear: got %h expected 00000002", rb);
    end
    bus_wr(0, BASE + 32'h8, 4'hF, 32'h2, a);
    vec++;
    if (done_s[0] !== 1'b0) begin
      miss++;
      $display("FAIL done_clear: got %b expected 0", done_s[0]);
    end
    // CMD of amount 1 completes on the same edge that accepts the following W1C.
    bus_wr(0, BASE, 4'hF, 32'h0000_0005, a);
    bus_wr(0, BASE + 32'h4, 4'hF, 32'h0000_0004, a);
    bus_wr(0, BASE + 32'h8, 4'hF, 32'h2, a);
    bus_rd(0, BASE + 32'hC, a, r, rb);
    vec++;
    if (done_s[0] !== 1'b1 || rb !== 32'h0000_000A) begin
      miss++;
      $display("FAIL set_wins: got done=%b res=%h expected 1 0000000A", done_s[0], rb);
    end
  endtask

  task automatic test_be();
    logic a, r;
    logic [31:0] m, v, rb;
    logic [3:0] b;
    bus_wr(1, BASE, 4'hF, 32'h0, a);
    bus_wr(1, BASE, 4'b0010, 32'hAABB_CCDD, a);
    bus_rd(1, BASE, a, r, rb);
    vec++;
    if (rb !== 32'h0000_CC00) begin
      miss++;
      $display("FAIL be_0010: got %h expected 0000CC00", rb);
    end
    m = 32'h0000_CC00;
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      b = 4'($urandom);
      for (int k = 0; k < 4; k++)
        if (b[k]) m[8*k +: 8] = v[8*k +: 8];
      bus_wr(1, BASE, b, v, a);
      bus_rd(1, BASE, a, r, rb);
      vec++;
      if (rb !== m) begin
        miss++;
        $display("FAIL be_rand%0d be=%b: got %h expected %h", i, b, rb, m);
      end
    end
    bus_rd(1, BASE + 32'h20, a, r, rb);
    vec++;
    if ({a, r, rb} !== 34'h0) begin
      miss++;
      $display("FAIL miss_read: got ack=%b resp=%b data=%h expected 0 0 0", a, r, rb);
    end
    bus_wr(1, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF, a);
    bus_rd(1, BASE, a, r, rb);
    vec++;
    if (rb !== m) begin
      miss++;
      $display("FAIL miss_write_ignored: got %h expected %h", rb, m);
    end
  endtask

  task automatic test_reset_mid_run();
    logic a, r;
    logic [31:0] rb, res;
    int lat, bc;
    bus_wr(0, BASE, 4'hF, 32'h8000_0000, a);
    bus_wr(0, BASE + 32'h4, 4'hF, 32'h0000_007F, a);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({busy_s, done_s, resp_s} !== 6'h0) begin
      miss++;
      $display("FAIL reset_mid_run: got busy=%b done=%b resp=%b expected 00 00 00",
               busy_s, done_s, resp_s);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_rd(0, BASE + 32'hC, a, r, rb);
    vec++;
    if (rb !== 32'h0) begin
      miss++;
      $display("FAIL reset_result: got %h expected 00000000", rb);
    end
    bus_rd(0, BASE + 32'h8, a, r, rb);
    vec++;
    if (rb !== 32'h0) begin
      miss++;
      $display("FAIL reset_status: got %h expected 00000000", rb);
    end
    do_shift(0, 32'h0000_00F0, 32'h0000_0010, lat, bc, res);
    vec++;
    if (res !== 32'h0000_0F00 || lat != 4) begin
      miss++;
      $display("FAIL after_reset_shift: got res=%h lat=%0d expected 00000F00 4", res, lat);
    end
  endtask

  initial begin
    req = '0;
    we  = '0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; be[d] = '0; last_res[d] = '0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_err();
    test_be();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
